// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with NZCV flag register, iterative shifts and optional multiplier
//
// Purpose:
//   Datapath ALU that sits between the register file and write-back. Requests
//   are accepted over a valid/ready handshake. Single-cycle ops finish on the
//   accept edge. Shifts/rotates move one bit per cycle. The optional multiplier
//   does one shift-add step per cycle. Result and NZCV flags are registered and
//   only change on a completion edge or on reset.
//
// Optional feature macro:
//   ALU_MUL_EN - when defined, opcode 14 is an iterative WIDTH-step multiply.
//                When undefined, opcode 14 returns SrcA in one cycle and
//                writes no flags.
//
// Ports:
//   clk                   rising-edge clock
//   reset_n               asynchronous active-low reset
//   InValid / InReady     request handshake (InReady high only when idle)
//   ALUControl, SetFlags  opcode and flag-write enable, sampled at accept
//   SrcA, SrcB            operands, sampled at accept
//   OutValid / OutReady   result handshake (result held until taken)
//   ALUResult             registered result
//   N, Z, CO, OVF         persistent flag register outputs
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic             SetFlags,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             N,
  output logic             Z,
  output logic             CO,
  output logic             OVF
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;  // counter must hold WIDTH for the multiply

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUBAB = 4'd1;
  localparam logic [3:0] OP_SUBBA = 4'd2;
  localparam logic [3:0] OP_BIC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_EXOR  = 4'd6;
  localparam logic [3:0] OP_EXNOR = 4'd7;
  localparam logic [3:0] OP_ADC   = 4'd8;
  localparam logic [3:0] OP_SBC   = 4'd9;
  localparam logic [3:0] OP_LSL   = 4'd10;
  localparam logic [3:0] OP_LSR   = 4'd11;
  localparam logic [3:0] OP_ASR   = 4'd12;
  localparam logic [3:0] OP_ROR   = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_MOV   = 4'd15;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             setf_q, setf_d;
  logic [WIDTH-1:0] work_q, work_d;   // shift operand, or multiplicand
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
`endif

  // Accept-path arithmetic: every add/sub is x + y + cin at WIDTH+1 bits.
  logic [WIDTH-1:0] ax, ay;
  logic             acin;
  logic [WIDTH:0]   sum;
  logic             arith_v;

  always_comb begin
    ax   = SrcA;
    ay   = SrcB;
    acin = 1'b0;
    case (ALUControl)
      OP_SUBAB: begin ay = ~SrcB; acin = 1'b1; end
      OP_SUBBA: begin ax = SrcB; ay = ~SrcA; acin = 1'b1; end
      OP_ADC:   begin acin = c_q; end
      OP_SBC:   begin ay = ~SrcB; acin = c_q; end
      default:  ;
    endcase
  end

  assign sum     = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, acin};
  assign arith_v = (ax[WIDTH-1] == ay[WIDTH-1]) && (sum[WIDTH-1] != ax[WIDTH-1]);

  logic [SW-1:0] amt;
  logic          is_shift;
  assign amt      = SrcB[SW-1:0];
  assign is_shift = (ALUControl == OP_LSL) || (ALUControl == OP_LSR) ||
                    (ALUControl == OP_ASR) || (ALUControl == OP_ROR);

  // Result and flag-write class for ops that complete on the accept edge.
  // Shifts only land here with amount 0, where the operand passes through.
  logic [WIDTH-1:0] one_res;
  logic             wr_nz, wr_cv;

  always_comb begin
    one_res = SrcA;
    wr_nz   = 1'b0;
    wr_cv   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUBAB, OP_SUBBA, OP_ADC, OP_SBC: begin
        one_res = sum[WIDTH-1:0];
        wr_nz   = 1'b1;
        wr_cv   = 1'b1;
      end
      OP_BIC:   begin one_res = SrcA & ~SrcB;    wr_nz = 1'b1; end
      OP_AND:   begin one_res = SrcA & SrcB;     wr_nz = 1'b1; end
      OP_OR:    begin one_res = SrcA | SrcB;     wr_nz = 1'b1; end
      OP_EXOR:  begin one_res = SrcA ^ SrcB;     wr_nz = 1'b1; end
      OP_EXNOR: begin one_res = ~(SrcA ^ SrcB);  wr_nz = 1'b1; end
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin one_res = SrcA; wr_nz = 1'b1; end
      OP_MUL:   begin one_res = SrcA; end
      OP_MOV:   begin one_res = SrcB; wr_nz = 1'b1; end
      default:  ;
    endcase
  end

  // One-bit shift step; step_out is the bit leaving the word this cycle.
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  always_comb begin
    step_val = work_q;
    step_out = c_q;
    case (op_q)
      OP_LSL: begin step_val = {work_q[WIDTH-2:0], 1'b0};          step_out = work_q[WIDTH-1]; end
      OP_LSR: begin step_val = {1'b0, work_q[WIDTH-1:1]};          step_out = work_q[0]; end
      OP_ASR: begin step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; step_out = work_q[0]; end
      OP_ROR: begin step_val = {work_q[0], work_q[WIDTH-1:1]};     step_out = work_q[0]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    setf_d  = setf_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
    mplr_d  = mplr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          op_d   = ALUControl;
          setf_d = SetFlags;
          work_d = SrcA;
          cnt_d  = CW'(amt);
          if (is_shift && (amt != '0)) begin
            state_d = ST_EXEC;
          end
`ifdef ALU_MUL_EN
          else if (ALUControl == OP_MUL) begin
            acc_d   = '0;
            mplr_d  = SrcB;
            cnt_d   = CW'(WIDTH);
            state_d = ST_EXEC;
          end
`endif
          else begin
            res_d   = one_res;
            state_d = ST_DONE;
            if (SetFlags && wr_nz) begin
              n_d = one_res[WIDTH-1];
              z_d = (one_res == '0);
            end
            if (SetFlags && wr_cv) begin
              c_d = sum[WIDTH];
              v_d = arith_v;
            end
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          // LSB-first shift-add; only the low WIDTH bits are kept.
          acc_d  = acc_q + (mplr_q[0] ? work_q : '0);
          work_d = {work_q[WIDTH-2:0], 1'b0};
          mplr_d = {1'b0, mplr_q[WIDTH-1:1]};
          if (cnt_q == CW'(1)) begin
            res_d   = acc_d;
            state_d = ST_DONE;
            if (setf_q) begin
              n_d = acc_d[WIDTH-1];
              z_d = (acc_d == '0);
            end
          end
        end else
`endif
        begin
          work_d = step_val;
          if (cnt_q == CW'(1)) begin
            res_d   = step_val;
            state_d = ST_DONE;
            if (setf_q) begin
              n_d = step_val[WIDTH-1];
              z_d = (step_val == '0);
              c_d = step_out;
            end
          end
        end
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      setf_q  <= 1'b0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q   <= '0;
      mplr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      setf_q  <= setf_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef ALU_MUL_EN
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
`endif
    end
  end

  assign InReady   = (state_q == ST_IDLE);
  assign OutValid  = (state_q == ST_DONE);
  assign ALUResult = res_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign CO        = c_q;
  assign OVF       = v_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc at WIDTH=8
module tb_alu_mc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [3:0]   ALUControl = 4'd0;
  logic         SetFlags = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         OutValid;
  logic         OutReady = 1'b1;
  logic [W-1:0] ALUResult;
  logic         N, Z, CO, OVF;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .SetFlags(SetFlags), .SrcA(SrcA), .SrcB(SrcB),
    .OutValid(OutValid), .OutReady(OutReady), .ALUResult(ALUResult),
    .N(N), .Z(Z), .CO(CO), .OVF(OVF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference flag state
  logic m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       sf;
    logic [7:0] er;
    logic       en, ez, ec, ev;
    int         elat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain arithmetic on integers, updates m_* flags.
  task automatic ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sf, output logic [7:0] r, output int lat);
    int ia = a;
    int ib = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int ci = m_c;
    int s  = ib % W;
    int sres = 0;
    logic wnz = 1'b1, wc = 1'b0, wv = 1'b0, nc = 1'b0;
    lat = 1;
    r = 8'h00;
    case (op)
      4'd0: begin r = a + b;  nc = (ia + ib) > 255; sres = sa + sb; wc = 1; wv = 1; end
      4'd1: begin r = a - b;  nc = ia >= ib;        sres = sa - sb; wc = 1; wv = 1; end
      4'd2: begin r = b - a;  nc = ib >= ia;        sres = sb - sa; wc = 1; wv = 1; end
      4'd3: r = a & ~b;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~(a ^ b);
      4'd8: begin r = 8'(ia + ib + ci); nc = (ia + ib + ci) > 255; sres = sa + sb + ci; wc = 1; wv = 1; end
      4'd9: begin r = 8'(ia - ib - 1 + ci); nc = (ia + ci) > ib; sres = sa - sb - 1 + ci; wc = 1; wv = 1; end
      4'd10: begin r = a << s; if (s > 0) begin nc = a[W-s]; wc = 1; end lat = s + 1; end
      4'd11: begin r = a >> s; if (s > 0) begin nc = a[s-1]; wc = 1; end lat = s + 1; end
      4'd12: begin r = 8'($signed(a) >>> s); if (s > 0) begin nc = a[s-1]; wc = 1; end lat = s + 1; end
      4'd13: begin r = (a >> s) | (a << (W - s)); if (s > 0) begin nc = a[s-1]; wc = 1; end lat = s + 1; end
`ifdef ALU_MUL_EN
      4'd14: begin r = 8'(ia * ib); lat = W + 1; end
`else
      4'd14: begin r = a; wnz = 1'b0; end
`endif
      default: r = b;
    endcase
    if (sf) begin
      if (wnz) begin m_n = r[7]; m_z = (r == 8'h00); end
      if (wc) m_c = nc;
      if (wv) m_v = (sres > 127) || (sres < -128);
    end
  endtask

  // Drive one op from a negedge with OutReady high, measure latency, compare.
  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic sf, input logic [7:0] er,
                        input logic en, input logic ez, input logic ec, input logic ev,
                        input int elat);
    int lat = 0;
    logic busy_ok = 1'b1;
    chk({name, "/inready"}, InReady, 1);
    ALUControl = op; SrcA = a; SrcB = b; SetFlags = sf; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    SrcA = 8'($urandom); SrcB = 8'($urandom);
    ALUControl = 4'($urandom); SetFlags = 1'($urandom);
    while (1) begin
      @(negedge clk);
      lat++;
      if (OutValid) break;
      if (InReady) busy_ok = 1'b0;
      if (lat > 40) break;
    end
    chk({name, "/latency"}, lat, elat);
    chk({name, "/busy"}, {busy_ok, InReady}, 2'b10);
    chk({name, "/result"}, ALUResult, er);
    chk({name, "/nzcv"}, {N, Z, CO, OVF}, {en, ez, ec, ev});
    @(negedge clk);
  endtask

  function automatic void add_vec(string nm, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                                  logic sf, logic [7:0] er, logic [3:0] nzcv, int elat);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.sf = sf; v.er = er;
    v.en = nzcv[3]; v.ez = nzcv[2]; v.ec = nzcv[1]; v.ev = nzcv[0]; v.elat = elat;
    vt.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] er;
    int elat;
    int lat;

    // Directed table; flags carry from row to row starting at reset (0000).
    add_vec("add_7f_01",    4'd0,  8'h7F, 8'h01, 1, 8'h80, 4'b1001, 1);
    add_vec("subab_eq",     4'd1,  8'h05, 8'h05, 1, 8'h00, 4'b0110, 1);
    add_vec("adc_nosf",     4'd8,  8'h10, 8'h20, 0, 8'h31, 4'b0110, 1);
    add_vec("and_nosf",     4'd4,  8'hF0, 8'h0F, 0, 8'h00, 4'b0110, 1);
    add_vec("lsl_81_1",     4'd10, 8'h81, 8'h01, 1, 8'h02, 4'b0010, 2);
    add_vec("asr_80_3",     4'd12, 8'h80, 8'h03, 1, 8'hF0, 4'b1000, 4);
    add_vec("ror_01_1",     4'd13, 8'h01, 8'h01, 1, 8'h80, 4'b1010, 2);
    add_vec("lsr_55_0",     4'd11, 8'h55, 8'h00, 1, 8'h55, 4'b0010, 1);
    add_vec("subba_neg",    4'd2,  8'h03, 8'h01, 1, 8'hFE, 4'b1000, 1);
    add_vec("sbc_ovf",      4'd9,  8'h80, 8'h01, 1, 8'h7E, 4'b0011, 1);
    add_vec("adc_carryin",  4'd8,  8'hFF, 8'h00, 1, 8'h00, 4'b0110, 1);
    add_vec("exnor",        4'd7,  8'h0F, 8'hF0, 1, 8'h00, 4'b0110, 1);
    add_vec("mov",          4'd15, 8'h00, 8'h9A, 1, 8'h9A, 4'b1010, 1);
`ifdef ALU_MUL_EN
    add_vec("mul_12_34",    4'd14, 8'h12, 8'h34, 1, 8'hA8, 4'b1010, 9);
`else
    add_vec("mul_off",      4'd14, 8'h12, 8'h34, 1, 8'h12, 4'b1010, 1);
`endif
    add_vec("ror_81_7",     4'd13, 8'h81, 8'h07, 1, 8'h03, 4'b0000, 8);
    add_vec("lsl_mod_amt",  4'd10, 8'h40, 8'h09, 1, 8'h80, 4'b1000, 2);
    add_vec("bic",          4'd3,  8'hFF, 8'h0F, 1, 8'hF0, 4'b1000, 1);
    add_vec("or_zero",      4'd5,  8'h00, 8'h00, 1, 8'h00, 4'b0100, 1);
    add_vec("exor_nosf",    4'd6,  8'hAA, 8'hAA, 0, 8'h00, 4'b0100, 1);
    add_vec("subab_m128",   4'd1,  8'h00, 8'h80, 1, 8'h80, 4'b1001, 1);
    add_vec("lsr_80_7",     4'd11, 8'h80, 8'h07, 1, 8'h01, 4'b0001, 8);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset/inready", InReady, 1);
    chk("reset/outvalid", OutValid, 0);
    chk("reset/result", ALUResult, 0);
    chk("reset/nzcv", {N, Z, CO, OVF}, 4'b0000);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vt[i])
      run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].sf, vt[i].er,
             vt[i].en, vt[i].ez, vt[i].ec, vt[i].ev, vt[i].elat);
    m_n = vt[vt.size()-1].en; m_z = vt[vt.size()-1].ez;
    m_c = vt[vt.size()-1].ec; m_v = vt[vt.size()-1].ev;

    // Backpressure: result held 5 cycles with OutReady low; InValid pulses ignored.
`ifdef ALU_MUL_EN
    ref_op(4'd14, 8'h0F, 8'h11, 1'b1, er, elat);
    ALUControl = 4'd14;
`else
    ref_op(4'd0, 8'h0F, 8'h11, 1'b1, er, elat);
    ALUControl = 4'd0;
`endif
    SrcA = 8'h0F; SrcB = 8'h11; SetFlags = 1'b1; InValid = 1'b1; OutReady = 1'b0;
    @(posedge clk); #1;
    InValid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (OutValid || lat > 40) break;
    end
    chk("hold/latency", lat, elat);
    for (int k = 0; k < 5; k++) begin
      chk("hold/outvalid", {OutValid, InReady}, 2'b10);
      chk("hold/result", ALUResult, er);
      chk("hold/nzcv", {N, Z, CO, OVF}, {m_n, m_z, m_c, m_v});
      InValid = (k == 1 || k == 3);
      ALUControl = 4'd15; SrcB = 8'h55; SetFlags = 1'b1;
      @(negedge clk);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    chk("hold/after_take", {OutValid, InReady}, 2'b01);
    chk("hold/after_result", ALUResult, er);

    // Random ops against the model
    for (int t = 0; t < 200; t++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic       sf;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      sf = 1'($urandom);
      ref_op(op, a, b, sf, er, elat);
      run_op($sformatf("rand%0d_op%0d", t, op), op, a, b, sf, er, m_n, m_z, m_c, m_v, elat);
    end

    // Reset while a shift is in flight
    ALUControl = 4'd10; SrcA = 8'h01; SrcB = 8'h07; SetFlags = 1'b1; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst/busy", InReady, 0);
    #1 reset_n = 1'b0;
    #2;
    chk("midrst/inready", InReady, 1);
    chk("midrst/outvalid", OutValid, 0);
    chk("midrst/result", ALUResult, 0);
    chk("midrst/nzcv", {N, Z, CO, OVF}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    @(negedge clk);
    chk("midrst/idle", {OutValid, InReady}, 2'b01);
    run_op("post_reset_adc", 4'd8, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
